// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register file geometry and the hard-wired zero register.
package cpu_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;

endpackage : cpu_pkg

// File: rtl/rf_scoreboard.sv
// Pending write-back scoreboard: one busy bit per register, set on issue, cleared on write-back.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    // Set applied after clear: a same-cycle issue is newer than the retiring write-back.
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  // A write-back in flight this cycle already satisfies the reader, matching the data bypass.
  assign busy1 = rst_n && busy_q[q_addr1] && !(clr_en && (clr_addr == q_addr1));
  assign busy2 = rst_n && busy_q[q_addr2] && !(clr_en && (clr_addr == q_addr2));

endmodule : rf_scoreboard

// File: rtl/reg_file.sv
// Two-read, one-write register file with write-through bypass, r0 hard-wired to zero,
// and a busy scoreboard for pending write-backs.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2
);

  localparam int                NREG      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;
  logic              hit1;
  logic              hit2;

  assign wr_ok = we && (waddr != ZERO_ADDR);
  assign hit1  = wr_ok && (waddr == raddr1);
  assign hit2  = wr_ok && (waddr == raddr2);

  // NOTE: the array is built from flops, not RAM, because reset must clear every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Reset gates the outputs directly so the bypass path cannot leak wdata during reset.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n) begin
      if (raddr1 != ZERO_ADDR) rdata1 = hit1 ? wdata : regs[raddr1];
      if (raddr2 != ZERO_ADDR) rdata2 = hit2 ? wdata : regs[raddr2];
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_en),
    .set_addr (issue_addr),
    .clr_en   (we),
    .clr_addr (waddr),
    .q_addr1  (raddr1),
    .q_addr2  (raddr2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        busy1;
  logic        busy2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy1      (busy1),
    .busy2      (busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and pending-write flags.
  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (we && waddr == a)    return wdata;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (we && waddr == a)    return 1'b0;
    return mbusy[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 5'd0) mreg[waddr] = wdata;
      if (we) mbusy[waddr] = 1'b0;
      if (issue_en && issue_addr != 5'd0) mbusy[issue_addr] = 1'b1;
    end
  end

  // Compare process: combinational outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    check("cmp_rdata1", rdata1, exp_rdata(raddr1));
    check("cmp_rdata2", rdata2, exp_rdata(raddr2));
    check("cmp_busy1",  32'(busy1), 32'(exp_busy(raddr1)));
    check("cmp_busy2",  32'(busy2), 32'(exp_busy(raddr2)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue_en = 1'b0;
  endtask

  initial begin
    // Reset held across edges while write/issue are requested: both must be ignored.
    we = 1'b1; waddr = 5'd5; wdata = 32'h1111_1111;
    issue_en = 1'b1; issue_addr = 5'd5; raddr1 = 5'd5; raddr2 = 5'd5;
    tick(); tick();
    #1;
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_busy2",  32'(busy2), 32'd0);
    idle();
    rst_n = 1'b1;
    #1;
    check("post_rst_r5", rdata1, 32'd0);
    check("post_rst_busy5", 32'(busy1), 32'd0);

    // Write r5, read back next cycle.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick(); idle(); raddr1 = 5'd5;
    #1 check("r5_readback", rdata1, 32'hDEAD_BEEF);

    // Writes to r0 are discarded, also on the bypass path.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    #1 check("r0_same_cycle", rdata1, 32'd0);
    tick(); idle();
    #1 check("r0_next_cycle", rdata1, 32'd0);

    // Same-cycle bypass on port 2.
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr2 = 5'd7;
    #1 check("bypass_rdata2", rdata2, 32'h1234_5678);
    tick(); idle();
    #1 check("r7_stored", rdata2, 32'h1234_5678);

    // Issue r9 -> busy next cycle; write-back clears it combinationally and after the edge.
    issue_en = 1'b1; issue_addr = 5'd9; raddr1 = 5'd9;
    #1 check("busy9_before_edge", 32'(busy1), 32'd0);
    tick(); idle();
    #1 check("busy9_set", 32'(busy1), 32'd1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0909;
    #1 check("busy9_wb_cycle", 32'(busy1), 32'd0);
    check("r9_bypass", rdata1, 32'h0000_0909);
    tick(); idle();
    #1 check("busy9_cleared", 32'(busy1), 32'd0);

    // Same-cycle issue and write-back to r3: set wins, data still lands.
    issue_en = 1'b1; issue_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_0003;
    raddr1 = 5'd3; raddr2 = 5'd3;
    tick(); idle();
    #1 check("busy3_set_wins", 32'(busy2), 32'd1);
    check("busy3_port1", 32'(busy1), 32'd1);
    check("r3_data", rdata2, 32'hCAFE_0003);
    check("r3_port1", rdata1, 32'hCAFE_0003);

    // Mid-cycle reset clears data and busy without a clock edge, bypass included.
    we = 1'b1; waddr = 5'd4; wdata = 32'hA5A5_A5A5; issue_en = 1'b1; issue_addr = 5'd4;
    tick(); idle(); raddr1 = 5'd4; raddr2 = 5'd4;
    #1 check("r4_loaded", rdata1, 32'hA5A5_A5A5);
    check("busy4_set", 32'(busy2), 32'd1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0001;
    #1 rst_n = 1'b0;
    #1 check("async_rst_rdata1", rdata1, 32'd0);
    check("async_rst_busy2", 32'(busy2), 32'd0);
    check("async_rst_busy1", 32'(busy1), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    #1 check("r4_after_rst", rdata1, 32'd0);

    // Randomized traffic over a small address window to exercise collisions.
    for (int c = 0; c < 3000; c++) begin
      tick();
      we         = 1'($urandom_range(0, 1));
      waddr      = 5'($urandom_range(0, 7));
      wdata      = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 7));
      raddr1     = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      raddr2     = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    end
    tick(); idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_file
